// File: rtl/bcd_scan_display.sv
// bcd_scan_display: decimal event counter driving a scanned common-anode 7-segment display
module bcd_scan_display #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50_000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc_pulse,
    input  logic                clr,
    output logic [4*DIGITS-1:0] count_bcd,
    output logic                wrap_pulse,
    output logic [DIGITS-1:0]   an,
    output logic [6:0]          seg
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;

    logic [4*DIGITS-1:0] count_inc;
    logic                carry;
    logic                zero_run;
    logic [DIGITS-1:0]   lz;
    logic [SW-1:0]       scan_cnt;
    logic [IW-1:0]       idx;
    logic [3:0]          digit;
    logic [6:0]          seg_dec;
    logic                blank;

    // ripple a +1 through the digits; carry left over means all digits were 9
    always_comb begin
        count_inc = count_bcd;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            count_inc[4*i +: 4] = carry ? (count_bcd[4*i +: 4] == 4'd9 ? 4'd0 : count_bcd[4*i +: 4] + 4'd1) : count_bcd[4*i +: 4];
            carry = carry && count_bcd[4*i +: 4] == 4'd9;
        end
    end

    // lz[i] is set when digit i and every digit above it are zero
    always_comb begin
        lz = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && count_bcd[4*i +: 4] == 4'd0;
            lz[i] = zero_run;
        end
    end

    // segment pattern {g,f,e,d,c,b,a} of the digit currently being scanned
    always_comb begin
        digit = count_bcd[4*idx +: 4];
        blank = BLANK_LZ && idx != '0 && lz[idx];
        case (digit)
            4'd0:    seg_dec = 7'h40;
            4'd1:    seg_dec = 7'h79;
            4'd2:    seg_dec = 7'h24;
            4'd3:    seg_dec = 7'h30;
            4'd4:    seg_dec = 7'h19;
            4'd5:    seg_dec = 7'h12;
            4'd6:    seg_dec = 7'h02;
            4'd7:    seg_dec = 7'h78;
            4'd8:    seg_dec = 7'h00;
            4'd9:    seg_dec = 7'h10;
            default: seg_dec = 7'h7F;
        endcase
    end

    // count register; clear beats increment, wrap flags only a real rollover
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            count_bcd  <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            count_bcd  <= inc_pulse ? count_inc : count_bcd;
            wrap_pulse <= inc_pulse && carry;
        end
    end

    // scan divider: hold each digit for SCAN_DIV cycles, then step to the next
    always_ff @(posedge clk) begin
        if (!rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= idx == IW'(DIGITS - 1) ? '0 : idx + IW'(1);
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    // registered pin drivers, dark while in reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            an  <= '1;
            seg <= 7'h7F;
        end else begin
            an  <= ~(DIGITS'(1) << idx);
            seg <= blank ? 7'h7F : seg_dec;
        end
    end
endmodule

// File: tb/tb_bcd_scan_display.sv
// tb_bcd_scan_display: directed checks of counting, wrap, priority, scan and blanking
module tb_bcd_scan_display;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inc_pulse = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] count0, count1;
    logic        wrap0, wrap1;
    logic [3:0]  an0, an1;
    logic [6:0]  seg0, seg1;
    int          tests = 0;
    int          fails = 0;
    int          k = 0;
    int          idx;
    logic [6:0]  seg_lz  [4] = '{7'h12, 7'h40, 7'h30, 7'h7F};
    logic [6:0]  seg_all [4] = '{7'h12, 7'h40, 7'h30, 7'h40};

    always #5 clk = ~clk;

    bcd_scan_display #(.DIGITS(4), .SCAN_DIV(4), .BLANK_LZ(1'b1)) dut_lz (
        .clk(clk), .rst(rst), .inc_pulse(inc_pulse), .clr(clr),
        .count_bcd(count0), .wrap_pulse(wrap0), .an(an0), .seg(seg0)
    );

    bcd_scan_display #(.DIGITS(4), .SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_all (
        .clk(clk), .rst(rst), .inc_pulse(inc_pulse), .clr(clr),
        .count_bcd(count1), .wrap_pulse(wrap1), .an(an1), .seg(seg1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        k++;
    endtask

    task automatic pulse(input int n);
        inc_pulse = 1'b1;
        repeat (n) cyc();
        inc_pulse = 1'b0;
    endtask

    function automatic logic [3:0] exp_an(input int kk);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << (((kk - 1) / 4) % 4));
    endfunction

    initial begin
        inc_pulse = 1'b1;
        repeat (3) cyc();
        check("rst_count", 32'(count0), 32'h0);
        check("rst_wrap", 32'(wrap0), 32'h0);
        check("rst_an", 32'(an0), 32'hF);
        check("rst_seg", 32'(seg0), 32'h7F);
        inc_pulse = 1'b0;
        rst = 1'b1;
        k = 0;
        cyc();
        check("first_an", 32'(an0), 32'hE);
        check("first_seg", 32'(seg0), 32'h40);
        repeat (3) cyc();
        check("hold_an", 32'(an0), 32'hE);
        cyc();
        check("step_an", 32'(an0), 32'hD);
        pulse(199);
        check("cnt_0199", 32'(count0), 32'h0199);
        pulse(1);
        check("cnt_0200", 32'(count0), 32'h0200);
        pulse(799);
        check("cnt_0999", 32'(count0), 32'h0999);
        pulse(1);
        check("cnt_1000", 32'(count0), 32'h1000);
        pulse(8999);
        check("cnt_9999", 32'(count0), 32'h9999);
        check("no_wrap", 32'(wrap0), 32'h0);
        pulse(1);
        check("wrap_cnt", 32'(count0), 32'h0);
        check("wrap_hi", 32'(wrap0), 32'h1);
        check("wrap_hi_b", 32'(wrap1), 32'h1);
        cyc();
        check("wrap_lo", 32'(wrap0), 32'h0);
        pulse(9999);
        check("cnt_9999b", 32'(count0), 32'h9999);
        clr = 1'b1;
        inc_pulse = 1'b1;
        cyc();
        clr = 1'b0;
        inc_pulse = 1'b0;
        check("clr_inc_cnt", 32'(count0), 32'h0);
        check("clr_inc_wrap", 32'(wrap0), 32'h0);
        pulse(42);
        check("cnt_0042", 32'(count0), 32'h0042);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        check("clr_cnt", 32'(count0), 32'h0);
        pulse(305);
        check("cnt_0305", 32'(count0), 32'h0305);
        for (int i = 0; i < 16; i++) begin
            cyc();
            idx = ((k - 1) / 4) % 4;
            check("scan_an", 32'(an0), 32'(exp_an(k)));
            check("scan_an_b", 32'(an1), 32'(exp_an(k)));
            check("scan_seg_lz", 32'(seg0), 32'(seg_lz[idx]));
            check("scan_seg_all", 32'(seg1), 32'(seg_all[idx]));
        end
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        pulse(123);
        check("cnt_0123", 32'(count0), 32'h0123);
        for (int i = 0; i < 16 && exp_an(k) != 4'b1011; i++) cyc();
        check("mid_an", 32'(an0), 32'hB);
        check("mid_seg", 32'(seg0), 32'h79);
        rst = 1'b0;
        cyc();
        check("mid_rst_cnt", 32'(count0), 32'h0);
        check("mid_rst_an", 32'(an0), 32'hF);
        check("mid_rst_seg", 32'(seg0), 32'h7F);
        check("mid_rst_wrap", 32'(wrap0), 32'h0);
        rst = 1'b1;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("restart_an", 32'(an0), 32'hE);
            check("restart_seg", 32'(seg0), 32'h40);
        end
        cyc();
        check("restart_an1", 32'(an0), 32'hD);
        check("restart_blank", 32'(seg0), 32'h7F);
        check("restart_noblank", 32'(seg1), 32'h40);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
